button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Front end for parking_meter. Takes the six raw pushbuttons (add1..add4, rst1, rst2).
//   Per channel: 2-FF synchronizer, counter debounce, then a one-clock press pulse.
//   btn_pulse drives the meter's add*/rst* inputs; btn_level is the debounced state.
// PARAMETERS
//   N_BTN           6        number of channels (bit0 add1, 1 add2, 2 add3, 3 add4, 4 rst1, 5 rst2)
//   DEBOUNCE_CYCLES 500000   consecutive stable synced cycles required to accept a change (>=2)
//   REPEAT_DELAY    50000000 cycles from press pulse to first auto-repeat pulse (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD   10000000 cycles between later auto-repeat pulses (AUTO_REPEAT_EN only)
//   REPEAT_MASK     6'b001111 channels allowed to auto-repeat (adds only; rst1/rst2 never repeat)
// PORTS
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   btn_raw    in   N_BTN  raw asynchronous button inputs, 1 = pressed
//   btn_level  out  N_BTN  debounced button state, registered
//   btn_pulse  out  N_BTN  one-clock-wide registered pulse on each accepted press
// BEHAVIOUR
//   Reset: all sync flops, counters, btn_level and btn_pulse clear to 0 immediately.
//     Raw inputs held high through reset are treated as new presses after release.
//   Synchronizer: s = btn_raw delayed through two flops. Only s is used downstream.
//   Debounce, per channel, independent:
//     - s == btn_level: count <= 0.
//     - s != btn_level: count <= count+1.
//     - When count == DEBOUNCE_CYCLES-1 and s still differs: btn_level <= s, count <= 0.
//     - Any single-cycle return of s to btn_level restarts the count from 0.
//   Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter saturates, never wraps.
//   Latency: raw goes stable at edge 0, so btn_level changes at edge 2+DEBOUNCE_CYCLES.
//     The same applies to release.
//   btn_pulse[i]: high for exactly the one cycle where btn_level[i] first reads 1.
//     It is never asserted on release.
//   Simultaneous events: all channels are fully independent. Same-cycle presses give
//     same-cycle pulses. There is no priority and no masking between channels.
//   Reset mid-count discards partial counts. After release a full DEBOUNCE_CYCLES is required.
//   No combinational path from btn_raw to any output.
// CONFIGURATION
//   AUTO_REPEAT_EN defined:
//     - Each channel in REPEAT_MASK has a repeat counter, cleared while btn_level=0.
//     - After the press pulse, extra pulses fire at +REPEAT_DELAY.
//     - Then further pulses fire every REPEAT_PERIOD while btn_level stays 1.
//     - Release stops repeats within the same cycle btn_level falls.
//     - Masked-out channels behave as without the macro.
//   AUTO_REPEAT_EN undefined:
//     - Exactly one pulse per accepted press.
//     - REPEAT_* parameters are ignored; no repeat logic is synthesized.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//   1. Reset: rst=1 with btn_raw=6'h3F -> btn_level=0, btn_pulse=0.
//      Release rst and hold raw -> level 6'h3F and one pulse 6'h3F at edge 6 after release.
//   2. Bounce: raw[2] high 3 cyc, low 1, high 3, low -> no level change, no pulse.
//      Then high 8 cyc -> single pulse on bit 2.
//   3. Release: after test 2 drop raw[2] -> btn_level[2] falls 6 edges later, btn_pulse stays 0.
//   4. Simultaneous: raw[0] and raw[3] rise same edge, raw[5] one edge later ->
//      pulse 6'b001001 in one cycle, then 6'b100000 next cycle.
//   5. Mid-count reset: raw[1] high, rst pulsed at count=3 -> all cleared.
//      Pulse arrives 6 edges after rst release, not earlier.
//   6. AUTO_REPEAT_EN: hold raw[3] for 40 cycles past accept -> pulses at t0, t0+10, +15, +20, ...
//      Hold raw[4] -> one pulse only. Without macro, raw[3] gives one pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Front end for the parking meter pushbuttons (add1..add4, rst1, rst2).
//   Each channel runs on its own: a two-flop synchronizer, then a counter
//   debounce, then a registered one-clock pulse on every accepted press.
//   btn_pulse feeds the meter's add*/rst* inputs. btn_level is the debounced
//   button state.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN):
//   When AUTO_REPEAT_EN is defined, the channels selected by REPEAT_MASK emit
//   extra pulses while held. The first extra pulse comes REPEAT_DELAY cycles
//   after the press pulse, and the rest follow every REPEAT_PERIOD cycles.
//   When the macro is undefined, no repeat logic exists and every accepted
//   press gives exactly one pulse.
//
// Parameters:
//   N_BTN           number of channels (bit0 add1 .. bit3 add4, bit4 rst1, bit5 rst2)
//   DEBOUNCE_CYCLES consecutive stable synchronized cycles needed to accept a change (>= 2)
//   REPEAT_DELAY    cycles from the press pulse to the first auto-repeat pulse
//   REPEAT_PERIOD   cycles between later auto-repeat pulses
//   REPEAT_MASK     channels allowed to auto-repeat
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   btn_raw    in   N_BTN  raw asynchronous button inputs, 1 = pressed
//   btn_level  out  N_BTN  debounced button state, registered
//   btn_pulse  out  N_BTN  one-clock registered pulse on each accepted press
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int               N_BTN           = 6,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter int               REPEAT_DELAY    = 50000000,
   parameter int               REPEAT_PERIOD   = 10000000,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(6'b001111)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse
);

   // The counter must be able to hold DEBOUNCE_CYCLES so that the saturation
   // guard is meaningful. Acceptance normally happens at DEBOUNCE_CYCLES-1.
   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   // Reject parameter sets that the debounce and repeat timing cannot honour.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || $countones(REPEAT_MASK) > N_BTN) begin : g_bad_repeat
      $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
   end

   // ---------------------------------------------------------------------
   // Two-flop synchronizer. Only r_sync2 (the "s" value) is used downstream.
   // ---------------------------------------------------------------------
   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Per-channel results are collected here. Each bit is driven by exactly
   // one generate instance.
   logic [N_BTN-1:0] w_level;
   logic [N_BTN-1:0] w_pulse;

   genvar gi;
   for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_pulse;
      logic             w_differ;
      logic             w_accept;
      logic             w_level_next;
      logic             w_rise;
      logic             w_rpt_fire;

      assign w_differ     = r_sync2[gi] ^ r_level;
      assign w_accept     = w_differ && (r_cnt == CNT_LAST);
      assign w_level_next = w_accept ? r_sync2[gi] : r_level;
      assign w_rise       = w_level_next & ~r_level;

      // Debounce counter. Any cycle where s agrees with the level restarts
      // the run. Acceptance also restarts the count, so the next change
      // needs a full new run.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
         end else begin
            r_level <= w_level_next;
            if (!w_differ || w_accept) begin
               r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

`ifdef AUTO_REPEAT_EN
      if (REPEAT_MASK[gi]) begin : g_rpt
         localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int RPT_W   = $clog2(RPT_MAX + 1);

         // Down-counter to the next repeat pulse. It is loaded with DELAY-1
         // on the press edge, so it reads zero exactly REPEAT_DELAY edges
         // later. It then reloads with PERIOD-1 each time it fires.
         logic [RPT_W-1:0] r_rpt;

         // Fire only while the level is already high and is staying high.
         // The press edge itself is covered by w_rise, and a release edge
         // suppresses the repeat in that same cycle.
         assign w_rpt_fire = r_level && w_level_next && (r_rpt == '0);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rpt <= '0;
            end else if (!w_level_next) begin
               r_rpt <= '0;
            end else if (w_rise) begin
               r_rpt <= RPT_W'(REPEAT_DELAY - 1);
            end else if (r_rpt == '0) begin
               r_rpt <= RPT_W'(REPEAT_PERIOD - 1);
            end else begin
               r_rpt <= r_rpt - 1'b1;
            end
         end
      end else begin : g_no_rpt
         assign w_rpt_fire = 1'b0;
      end
`else
      assign w_rpt_fire = 1'b0;
`endif

      // The pulse is registered in the same edge where the level first
      // becomes 1, so both outputs change together.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_pulse <= 1'b0;
         end else begin
            r_pulse <= w_rise | w_rpt_fire;
         end
      end

      assign w_level[gi] = r_level;
      assign w_pulse[gi] = r_pulse;
   end

   assign btn_level = w_level;
   assign btn_pulse = w_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int NB   = 6;
   localparam int DB   = 4;
   localparam int RD   = 10;
   localparam int RP   = 5;
   localparam int HALF = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pulse;

   int total = 0;
   int bad   = 0;

   always #HALF clk = ~clk;

   button_conditioner #(
      .N_BTN(NB),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP),
      .REPEAT_MASK(6'b001111)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse)
   );

   // ------------------------------------------------------------------
   // Reference model.
   // The model keeps a history of raw samples, one per clock edge. The
   // value s seen at edge k is the raw sample from edge k-2. A channel's
   // level flips at edge k when the DB values of s at edges k-DB+1..k, that
   // is raw samples k-1-DB..k-2, all differ from the current level. Each
   // expected pulse vector is queued with the time of the edge that
   // produces it.
   // ------------------------------------------------------------------
   typedef struct {
      longint        t;
      logic [NB-1:0] v;
   } exp_t;

   exp_t          exp_q[$];
   logic [NB-1:0] hist [0:DB+1];
   logic [NB-1:0] m_level = '0;
   longint        press_t [NB];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= DB + 1; j++) hist[j] = '0;
         m_level = '0;
         exp_q.delete();
      end else begin
         logic [NB-1:0] want;
         logic          all_diff;
         longint        el;
`ifdef AUTO_REPEAT_EN
         logic [NB-1:0] rmask;
         rmask = 6'b001111;
`endif
         for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = btn_raw;
         want = '0;
         for (int c = 0; c < NB; c++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
               if (hist[j][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) begin
                  want[c]    = 1'b1;
                  press_t[c] = $time;
               end
            end else if (m_level[c]) begin
               el = ($time - press_t[c]) / (2 * HALF);
`ifdef AUTO_REPEAT_EN
               if (rmask[c] && (el == RD || (el > RD && (el - RD) % RP == 0)))
                  want[c] = 1'b1;
`endif
            end
         end
         if (want != '0) exp_q.push_back('{$time, want});
      end
   end

   // ------------------------------------------------------------------
   // Monitor: compares on the falling edge, away from the active edge.
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      total++;
      if (btn_level !== m_level) begin
         bad++;
         $display("FAIL level t=%0t got=%b want=%b", $time, btn_level, m_level);
      end
      if (btn_pulse !== '0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pulse_unexpected t=%0t got=%b want=none", $time, btn_pulse);
         end else begin
            e = exp_q.pop_front();
            if (e.v !== btn_pulse || e.t + HALF != $time) begin
               bad++;
               $display("FAIL pulse t=%0t got=%b want=%b@%0t", $time, btn_pulse, e.v, e.t + HALF);
            end else begin
               $display("pulse ok t=%0t v=%b", $time, btn_pulse);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].t + HALF <= $time) begin
         total++;
         bad++;
         e = exp_q.pop_front();
         $display("FAIL pulse_missing t=%0t got=%b want=%b", $time, btn_pulse, e.v);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus: raw inputs change 2 ns after a rising edge.
   // ------------------------------------------------------------------
   task automatic apply(input logic [NB-1:0] v, input int n);
      btn_raw = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      logic [NB-1:0] rv;
      int            rn;

      // Reset with every raw input held high, then release.
      btn_raw = '1;
      rst     = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b0;
      apply(6'h3F, 12);
      apply(6'h00, 10);

      // Bounce on bit 2, then a clean press and release.
      apply(6'h04, 3);
      apply(6'h00, 1);
      apply(6'h04, 3);
      apply(6'h00, 8);
      apply(6'h04, 8);
      apply(6'h00, 10);

      // Simultaneous presses, with bit 5 one edge behind.
      apply(6'h09, 1);
      apply(6'h29, 12);
      apply(6'h00, 10);

      // Reset in the middle of a count.
      apply(6'h02, 5);
      rst = 1'b1;
      apply(6'h02, 2);
      rst = 1'b0;
      apply(6'h02, 10);
      apply(6'h00, 10);

      // Long holds: a repeat-capable channel, then a reset channel.
      apply(6'h08, 50);
      apply(6'h00, 10);
      apply(6'h10, 50);
      apply(6'h00, 10);

      // Randomized traffic with an occasional reset.
      for (int i = 0; i < 300; i++) begin
         rv = NB'($urandom);
         if ($urandom_range(0, 3) == 0) rv = '0;
         rn = $urandom_range(1, 9);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            apply(rv, 1);
            rst = 1'b0;
         end
         apply(rv, rn);
      end
      apply(6'h00, 30);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0 pending pulses", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
